// File: rtl/s2_pkg.sv
// -----------------------------------------------------------------------------
// s2_pkg
// Shared constants for the s2 selector/arbiter stage.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input of s2_arb_mux
//   DEF_WIDTH            : default data word width in bits
//   DEF_CHANNELS         : default number of input channels (power of two, >= 2)
// -----------------------------------------------------------------------------
package s2_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH    = 5;
  localparam int DEF_CHANNELS = 4;

endpackage : s2_pkg

// File: rtl/s2_arb_mux_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Starting at index 'base' and wrapping
// modulo CHANNELS, the first asserted bit of 'req' wins.
//   req     in  CHANNELS  request vector
//   base    in  SELW      index that receives the highest priority
//   gnt     out SELW      index of the winning request (0 when none)
//   gnt_vld out 1         at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     base,
  output logic [SELW-1:0]     gnt,
  output logic                gnt_vld
);

  always_comb begin
    logic [SELW-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_vld = 1'b0;
    // CHANNELS is a power of two, so the SELW-bit add wraps for free.
    for (int i = 0; i < CHANNELS; i++) begin
      idx = base + SELW'(i);
      if (!gnt_vld && req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/s2_arb_mux.sv
// -----------------------------------------------------------------------------
// s2_arb_mux
// Selects one of CHANNELS input words and registers it into a single-entry
// output stage. Selection is either a fixed channel index (sel) or round-robin
// over the valid channels. Valid/ready handshakes on every side; there is no
// skid buffer, so out_ready feeds in_ready combinationally.
//
// Ports
//   clk       in  1               rising-edge clock
//   CLR_n     in  1               synchronous active-low reset
//   mode      in  1               MODE_FIXED (0) or MODE_RR (1)
//   sel       in  SELW            channel used in fixed mode
//   flush     in  1               clears the output stage, blocks transfers
//   in_data   in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  in  CHANNELS        per-channel valid
//   in_ready  out CHANNELS        one-hot (granted channel) or zero
//   out_data  out WIDTH           registered selected word
//   out_chan  out SELW            registered source channel index
//   out_valid out 1               output stage holds a word
//   out_ready in  1               consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module s2_arb_mux
  import s2_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      CLR_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Output stage and arbitration state
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  chan_p1;
  logic             vld_p1;
  logic [SELW-1:0]  ptr;      // last channel that transferred

  // Grant decision
  logic [SELW-1:0]  rr_base_p0;
  logic [SELW-1:0]  rr_gnt_p0;
  logic             rr_vld_p0;
  logic [SELW-1:0]  gnt_p0;
  logic             gnt_vld_p0;
  logic             load_p0;
  logic             xfer_p0;
  logic [WIDTH-1:0] word_p0;

  // Round-robin search starts one past the last winner.
  assign rr_base_p0 = ptr + 1'b1;

  rr_pick #(
    .CHANNELS (CHANNELS)
  ) u_rr_pick (
    .req     (in_valid),
    .base    (rr_base_p0),
    .gnt     (rr_gnt_p0),
    .gnt_vld (rr_vld_p0)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      gnt_p0     = rr_gnt_p0;
      gnt_vld_p0 = rr_vld_p0;
    end else begin
      // Fixed mode looks only at the selected channel's valid.
      gnt_p0     = sel;
      gnt_vld_p0 = in_valid[sel];
    end
  end

  // The stage can take a word when empty or when its word leaves this cycle.
  assign load_p0 = !vld_p1 || out_ready;

  // A grant only exists where in_valid is set, so an offered ready is always
  // a transfer. Reset and flush both suppress it.
  assign xfer_p0 = CLR_n && !flush && load_p0 && gnt_vld_p0;

  always_comb begin
    in_ready         = '0;
    in_ready[gnt_p0] = xfer_p0;
  end

  assign word_p0 = in_data[gnt_p0*WIDTH +: WIDTH];

  // ---- stage p0 -> p1 : output register ----
  always_ff @(posedge clk) begin
    if (!CLR_n) begin
      data_p1 <= '0;
      chan_p1 <= '0;
      vld_p1  <= 1'b0;
      // Points at the last channel so the first search begins at channel 0.
      ptr     <= SELW'(CHANNELS - 1);
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (xfer_p0) begin
      data_p1 <= word_p0;
      chan_p1 <= gnt_p0;
      vld_p1  <= 1'b1;
      // Updated in fixed mode too, so a later switch to round-robin stays fair.
      ptr     <= gnt_p0;
    end else if (out_ready) begin
      // Drain with no replacement; data and channel keep their last value.
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule : s2_arb_mux

// File: doc/s2_arb_mux.md
# s2_arb_mux

Parametrised successor to the two-level selector-plus-register stage. It selects one of CHANNELS input words of WIDTH bits and registers it into a single-entry output stage with valid/ready handshakes on every side. Selection is either fixed, by an explicit select input, or round-robin arbitration over the valid channels. It sits between multiple producers and one registered consumer in the datapath.

## Interface
- WIDTH, 5, data word width in bits
- CHANNELS, 4, number of input channels; ≥2, power of two
- SELW, $clog2(CHANNELS), select/channel-index width (derived, not overridden)

- clk  in  1  rising-edge clock
- CLR_n  in  1  reset; synchronous, active-low: sampled only on rising clk, asserted when 0
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- flush  in  1  synchronous clear of output stage (non-reset)
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel i at bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready; one-hot or zero
- out_data  out  WIDTH  registered selected word
- out_chan  out  SELW  registered index of source channel
- out_valid  out  1  output stage holds a word
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- load = !out_valid || out_ready. Output stage may capture when load = 1.
- Fixed mode:
  - grant = sel when in_valid[sel] = 1; otherwise no grant.
  - Other channels' valids are ignored.
- Round-robin mode:
  - Search starts at (ptr+1) mod CHANNELS and wraps.
  - The first channel with in_valid = 1 wins.
  - No valid channel means no grant.
- in_ready[g] = load && grant exists. All other in_ready bits are 0. in_ready is combinational from in_valid, mode, sel, out_valid, out_ready and ptr.
- Transfer on channel g: in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← word g, out_chan ← g, out_valid ← 1.
  - ptr ← g. ptr updates only on a transfer, in either mode, so returning to round-robin resumes fairly.
- Drain without a new transfer (out_valid && out_ready, no grant): out_valid ← 0, out_data and out_chan hold.
- Stall (out_valid && !out_ready): all outputs hold, in_ready = 0.
- flush = 1:
  - out_valid ← 0 on that edge. No transfer occurs (in_ready forced 0 that cycle). ptr holds.
  - out_data and out_chan hold.
- Mode or sel changes affect only the next grant decision, never the word already held.
- Reset (CLR_n = 0 at an edge) has priority over everything and may occur mid-transfer; the in-flight word is discarded.
  - out_valid = 0, out_data = 0, out_chan = 0.
  - ptr = CHANNELS-1, so the first round-robin search begins at channel 0.
  - in_ready = 0 while CLR_n = 0.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held at 1.
- No combinational path from in_data to out_data.
- The out_ready → in_ready path is combinational. There is no skid buffer; this is the documented single-entry behaviour.
- Round-robin fairness: with all channels valid and out_ready = 1, grants go 0,1,2,…,CHANNELS-1,0 on consecutive cycles.

## Structure
- Package s2_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - Default WIDTH and CHANNELS constants.
- Sub-module rr_pick (parameter CHANNELS): combinational rotating-priority search.
  - Inputs: req vector, base index.
  - Outputs: grant index, grant-valid.
- The top level holds the output register, ptr and the handshake logic.

## Test plan
- Reset: CLR_n = 0 for 2 cycles with all in_valid = 1 → out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0. First RR grant after release is channel 0.
- Fixed mode, sel = 2, in_valid = 4'b1111, ch2 = 5'h15, out_ready = 1 → in_ready = 4'b0100; next cycle out_data = 5'h15, out_chan = 2. With sel = 2, in_valid = 4'b1011 → no grant, out_valid drops after the drain.
- RR mode, all valid, channel i data = i+1, out_ready = 1 for 6 cycles → out_chan sequence 0,1,2,3,0,1, out_data 1,2,3,4,1,2.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles while in_valid changes → out_data held, in_ready = 0. Raise out_ready → drain and new capture in the same cycle.
- RR skip/wrap: ptr = 1, in_valid = 4'b0001 → grant 0 via wrap. Then in_valid = 4'b1001 → grant 3.
- Flush and mid-operation reset:
  - flush during a would-be transfer → out_valid = 0 next cycle, no in_ready, ptr unchanged.
  - CLR_n = 0 during a transfer → the word is discarded and outputs are at reset values.
